swap_mem_responder: RTL and testbench

- Memory-side responder for the two-bank swap initiator; serves the mem_a_* and mem_b_* request ports of the swap engine.
- Holds two independent banks of DEPTH words: combinational read, posted one-entry write buffer per bank with read forwarding.
- Zero-fills both banks after reset, then raises ready.
- Used as a concrete RTL memory model when running the swap engine outside the abstract-memory verification wrapper.

---
 rtl/swap_mem_pkg.sv | 11 +
 rtl/swap_mem_bank.sv | 56 +++++
 rtl/swap_mem_responder.sv | 59 +++++
 tb/tb_swap_mem_responder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/swap_mem_pkg.sv
// swap_mem_pkg: shared state encoding and index-width helper for the swap memory responder
package swap_mem_pkg;
  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  localparam int IDX_W = clog2(16);
endpackage

// File: rtl/swap_mem_bank.sv
// swap_mem_bank: one memory bank with combinational read, posted write buffer and forwarding
module swap_mem_bank
  import swap_mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 8,
  parameter int DEPTH = 16,
  parameter int CW = 8,
  localparam int IW = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ready,
  input  logic          clr,
  input  logic [IW-1:0] clr_idx,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          wen,
  output logic          oor,
  output logic [CW-1:0] wr_cnt
);
  logic [DW-1:0] mem [DEPTH];
  logic          pend_v;
  logic [IW-1:0] pend_a;
  logic [DW-1:0] pend_d;
  logic          r_ok, w_ok, acc;
  assign r_ok = raddr < AW'(DEPTH);
  assign w_ok = waddr < AW'(DEPTH);
  assign acc = ready && wen && w_ok;
  assign oor = ready && wen && !w_ok;
  // read path: pending write takes priority over the array for a matching address
  always_comb
    rdata = (!ready || !r_ok) ? '0 :
            (pend_v && pend_a == raddr[IW-1:0]) ? pend_d : mem[raddr[IW-1:0]];
  // array update: zero-fill while clearing, otherwise retire the pending entry; nothing lands during reset
  always_ff @(posedge clk)
    if (!rst) begin
      if (clr) mem[clr_idx] <= '0;
      else if (ready && pend_v) mem[pend_a] <= pend_d;
    end
  // pending buffer and saturating accepted-write counter
  always_ff @(posedge clk)
    if (rst) begin
      pend_v <= 1'b0;
      wr_cnt <= '0;
    end else if (ready) begin
      pend_v <= acc;
      if (acc) begin
        pend_a <= waddr[IW-1:0];
        pend_d <= wdata;
        wr_cnt <= wr_cnt + CW'(wr_cnt != '1);
      end
    end
endmodule

// File: rtl/swap_mem_responder.sv
// swap_mem_responder: two-bank memory model with post-reset zero-fill for the swap initiator
module swap_mem_responder
  import swap_mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 8,
  parameter int DEPTH = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] mem_a_raddr,
  output logic [DW-1:0] mem_a_rdata,
  input  logic [AW-1:0] mem_a_waddr,
  input  logic [DW-1:0] mem_a_wdata,
  input  logic          mem_a_wen,
  input  logic [AW-1:0] mem_b_raddr,
  output logic [DW-1:0] mem_b_rdata,
  input  logic [AW-1:0] mem_b_waddr,
  input  logic [DW-1:0] mem_b_wdata,
  input  logic          mem_b_wen,
  output logic          ready,
  output logic          oor_err,
  output logic [CW-1:0] wr_cnt_a,
  output logic [CW-1:0] wr_cnt_b
);
  localparam int IW = clog2(DEPTH);
  state_t        state_q, state_d;
  logic [IW-1:0] clr_idx_q, clr_idx_d;
  logic          oor_a, oor_b, clr;
  assign ready = state_q == READY;
  assign clr = state_q == CLEAR;
  // clear sequencing: walk every index once, then sit in READY until reset
  always_comb begin
    state_d = (clr && clr_idx_q == IW'(DEPTH - 1)) ? READY : state_q;
    clr_idx_d = clr ? clr_idx_q + 1'b1 : clr_idx_q;
  end
  // state register, clear index and sticky out-of-range flag
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= CLEAR;
      clr_idx_q <= '0;
      oor_err <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_idx_q <= clr_idx_d;
      if (oor_a || oor_b) oor_err <= 1'b1;
    end
  swap_mem_bank #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .CW(CW)) u_a (
    .clk(clk), .rst(rst), .ready(ready), .clr(clr), .clr_idx(clr_idx_q),
    .raddr(mem_a_raddr), .rdata(mem_a_rdata), .waddr(mem_a_waddr), .wdata(mem_a_wdata),
    .wen(mem_a_wen), .oor(oor_a), .wr_cnt(wr_cnt_a)
  );
  swap_mem_bank #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .CW(CW)) u_b (
    .clk(clk), .rst(rst), .ready(ready), .clr(clr), .clr_idx(clr_idx_q),
    .raddr(mem_b_raddr), .rdata(mem_b_rdata), .waddr(mem_b_waddr), .wdata(mem_b_wdata),
    .wen(mem_b_wen), .oor(oor_b), .wr_cnt(wr_cnt_b)
  );
endmodule

// File: tb/tb_swap_mem_responder.sv
// tb_swap_mem_responder: directed stimulus with a per-cycle behavioural model and literal checkpoints
module tb_swap_mem_responder;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] mem_a_raddr = 0, mem_a_waddr = 0, mem_b_raddr = 0, mem_b_waddr = 0;
  logic [7:0]  mem_a_rdata, mem_b_rdata, mem_a_wdata = 0, mem_b_wdata = 0;
  logic        mem_a_wen = 0, mem_b_wen = 0;
  logic        ready, oor_err;
  logic [7:0]  wr_cnt_a, wr_cnt_b;
  int          n_cmp = 0, n_bad = 0;
  logic        go = 1'b0;
  logic [7:0]  ma [16], mb [16];
  int          m_cnt;
  logic        m_oor;
  int          m_ca, m_cb;
  logic [7:0]  ra, rb;

  swap_mem_responder dut (
    .clk(clk), .rst(rst),
    .mem_a_raddr(mem_a_raddr), .mem_a_rdata(mem_a_rdata), .mem_a_waddr(mem_a_waddr),
    .mem_a_wdata(mem_a_wdata), .mem_a_wen(mem_a_wen),
    .mem_b_raddr(mem_b_raddr), .mem_b_rdata(mem_b_rdata), .mem_b_waddr(mem_b_waddr),
    .mem_b_wdata(mem_b_wdata), .mem_b_wen(mem_b_wen),
    .ready(ready), .oor_err(oor_err), .wr_cnt_a(wr_cnt_a), .wr_cnt_b(wr_cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // model: memory contents as seen by a reader, ready after 16 non-reset edges
  always @(posedge clk)
    if (rst) begin
      m_cnt <= 0;
      m_oor <= 1'b0;
      m_ca <= 0;
      m_cb <= 0;
      for (int i = 0; i < 16; i++) begin
        ma[i] <= 8'h00;
        mb[i] <= 8'h00;
      end
    end else begin
      if (m_cnt < 16) m_cnt <= m_cnt + 1;
      if (m_cnt == 16) begin
        if (mem_a_wen && mem_a_waddr < 16) begin
          ma[mem_a_waddr[3:0]] <= mem_a_wdata;
          m_ca <= (m_ca == 255) ? 255 : m_ca + 1;
        end
        if (mem_b_wen && mem_b_waddr < 16) begin
          mb[mem_b_waddr[3:0]] <= mem_b_wdata;
          m_cb <= (m_cb == 255) ? 255 : m_cb + 1;
        end
        if ((mem_a_wen && mem_a_waddr >= 16) || (mem_b_wen && mem_b_waddr >= 16)) m_oor <= 1'b1;
      end
    end

  // per-cycle comparison against the model
  always @(negedge clk)
    if (go) begin
      chk("ready", {31'd0, ready}, {31'd0, m_cnt == 16});
      chk("oor_err", {31'd0, oor_err}, {31'd0, m_oor});
      chk("wr_cnt_a", {24'd0, wr_cnt_a}, m_ca);
      chk("wr_cnt_b", {24'd0, wr_cnt_b}, m_cb);
      chk("rdata_a", {24'd0, mem_a_rdata},
          {24'd0, (m_cnt == 16 && mem_a_raddr < 16) ? ma[mem_a_raddr[3:0]] : 8'h00});
      chk("rdata_b", {24'd0, mem_b_rdata},
          {24'd0, (m_cnt == 16 && mem_b_raddr < 16) ? mb[mem_b_raddr[3:0]] : 8'h00});
    end

  initial begin
    repeat (3) cyc;
    go = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #2 chk("ready_low", {31'd0, ready}, 0);
      cyc;
    end
    #2 chk("ready_high", {31'd0, ready}, 1);
    for (int i = 0; i < 16; i++) begin
      mem_a_raddr = i;
      mem_b_raddr = i;
      #2 chk("zero_a", {24'd0, mem_a_rdata}, 0);
      chk("zero_b", {24'd0, mem_b_rdata}, 0);
      cyc;
    end
    mem_a_waddr = 3; mem_a_wdata = 8'h5A; mem_a_wen = 1; mem_a_raddr = 3;
    #2 chk("a3_same_cycle", {24'd0, mem_a_rdata}, 0);
    cyc;
    mem_a_wen = 0;
    #2 chk("a3_fwd", {24'd0, mem_a_rdata}, 32'h5A);
    cyc; cyc;
    #2 chk("a3_array", {24'd0, mem_a_rdata}, 32'h5A);
    chk("cnt_a_1", {24'd0, wr_cnt_a}, 1);
    chk("cnt_b_0", {24'd0, wr_cnt_b}, 0);
    mem_a_waddr = 2; mem_a_wdata = 8'h11; mem_a_wen = 1;
    mem_b_waddr = 7; mem_b_wdata = 8'h22; mem_b_wen = 1;
    cyc;
    mem_a_wen = 0; mem_b_wen = 0;
    cyc;
    mem_a_raddr = 2; mem_b_raddr = 7;
    #1 ra = mem_a_rdata; rb = mem_b_rdata;
    mem_a_wdata = rb; mem_b_wdata = ra; mem_a_wen = 1; mem_b_wen = 1;
    cyc;
    mem_a_wen = 0; mem_b_wen = 0;
    cyc;
    #2 chk("swap_a2", {24'd0, mem_a_rdata}, 32'h22);
    chk("swap_b7", {24'd0, mem_b_rdata}, 32'h11);
    chk("swap_cnt_a", {24'd0, wr_cnt_a}, 3);
    chk("swap_cnt_b", {24'd0, wr_cnt_b}, 2);
    cyc;
    mem_a_raddr = 4; mem_a_waddr = 4; mem_a_wdata = 8'hAA; mem_a_wen = 1;
    #2 chk("a4_old", {24'd0, mem_a_rdata}, 0);
    cyc;
    mem_a_wdata = 8'hBB;
    #2 chk("a4_aa", {24'd0, mem_a_rdata}, 32'hAA);
    cyc;
    mem_a_wen = 0;
    #2 chk("a4_bb", {24'd0, mem_a_rdata}, 32'hBB);
    cyc;
    #2 chk("a4_bb_array", {24'd0, mem_a_rdata}, 32'hBB);
    cyc;
    mem_b_waddr = 32'h20; mem_b_wdata = 8'h99; mem_b_wen = 1; mem_b_raddr = 32'h20;
    cyc;
    mem_b_wen = 0;
    #2 chk("oor_set", {31'd0, oor_err}, 1);
    chk("oor_rd", {24'd0, mem_b_rdata}, 0);
    chk("oor_cnt_b", {24'd0, wr_cnt_b}, 2);
    cyc;
    mem_b_raddr = 0;
    #2 chk("b0_intact", {24'd0, mem_b_rdata}, 0);
    chk("oor_sticky", {31'd0, oor_err}, 1);
    cyc;
    mem_a_waddr = 32'h1000_0003; mem_a_wdata = 8'hEE; mem_a_wen = 1; mem_a_raddr = 3;
    cyc;
    mem_a_wen = 0;
    cyc;
    #2 chk("no_alias_a3", {24'd0, mem_a_rdata}, 32'h5A);
    chk("no_alias_cnt", {24'd0, wr_cnt_a}, 5);
    mem_a_waddr = 0; mem_a_wen = 1;
    for (int i = 0; i < 260; i++) begin
      mem_a_wdata = i[7:0];
      cyc;
    end
    mem_a_wen = 0; mem_a_raddr = 0;
    #2 chk("cnt_a_sat", {24'd0, wr_cnt_a}, 255);
    chk("a0_last", {24'd0, mem_a_rdata}, 32'h03);
    cyc;
    mem_a_waddr = 1; mem_a_wdata = 8'h77; mem_a_wen = 1; mem_a_raddr = 1;
    cyc;
    mem_a_wen = 0; rst = 1;
    cyc;
    rst = 0;
    #2 chk("rst_ready", {31'd0, ready}, 0);
    chk("rst_oor", {31'd0, oor_err}, 0);
    chk("rst_cnt_a", {24'd0, wr_cnt_a}, 0);
    chk("rst_cnt_b", {24'd0, wr_cnt_b}, 0);
    repeat (16) cyc;
    #2 chk("rst_ready_again", {31'd0, ready}, 1);
    chk("a1_discarded", {24'd0, mem_a_rdata}, 0);
    cyc;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
